step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
- Control-step generator for the Simple CPU control unit.
- Produces the 5-bit step code consumed by the binary-to-onehot step decoder directly downstream.
- Code 0 means no step active (decoder output all zeros); codes 1..MAX_STEP select timing steps T1..Tn.
- Sequences each instruction through its steps, supports stalls, early instruction completion, back-to-back instructions, halt/resume, and counts retired instructions.

Parameters:
STEP_W, 5, width of step_code; must match decoder input width.
MAX_STEP, 10, last legal step code; 1 <= MAX_STEP <= 2^STEP_W-1 and within decoder's decoded range.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high; dominates all other inputs.
start  input  1  begin a new instruction at step 1.
enable  input  1  advance one step this cycle; low = stall/hold.
done  input  1  current instruction completes at the current step.
halt  input  1  stop sequencing; enter HALTED.
resume  input  1  leave HALTED, return to IDLE.
step_code  output  STEP_W  current step, 0 = idle/halted; feeds decoder.
busy  output  1  high while in RUN.
halted  output  1  high while in HALTED.
last_step  output  1  RUN and step_code == MAX_STEP.
step_err  output  1  sticky overrun flag.
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- All outputs registered or decoded from registered state only. No combinational input-to-output path. Input sampled at edge N takes effect at outputs after edge N.
- Reset (sync, active-high): state IDLE, step_code 0, busy 0, halted 0, step_err 0, instr_count 0. Reset mid-RUN aborts without counting.
- States: IDLE, RUN, HALTED. Encoding constants live in the package.
- IDLE:
  - halt -> HALTED.
  - Else start -> RUN, step_code 1.
  - Else hold step_code 0.
  - enable, done, resume ignored.
- RUN, priority halt > done > !enable > advance:
  - halt: -> HALTED, step_code 0, instr_count unchanged even if done is also high.
  - done: instr_count+1. If start is also high -> stay RUN, step_code 1 (back-to-back, busy stays 1). Else -> IDLE, step_code 0. enable is irrelevant.
  - !enable: hold state and step_code.
  - enable, step_code < MAX_STEP: step_code+1.
  - enable, step_code == MAX_STEP (overrun): step_err set to 1, -> IDLE, step_code 0, instr_count unchanged.
- HALTED:
  - step_code 0.
  - resume -> IDLE.
  - start, halt, done, enable ignored.
  - resume and start in the same cycle: only resume acts; start is not honoured.
- step_err is sticky; only reset clears it. Sequencing continues normally after an overrun.
- instr_count wraps from all-ones to 0 with no flag.
- step_code is never outside 0..MAX_STEP.
- busy = (state == RUN). halted = (state == HALTED).

Decomposition:
- Shared control package holds:
  - state encodings IDLE/RUN/HALTED
  - STEP_IDLE = 0
  - default STEP_W, MAX_STEP
- The decoder stage also uses STEP_W and MAX_STEP from the package.
- Single flat module; no sub-module. The instruction counter stays inline.
- The step decoder is instantiated by the parent control unit, not inside this block.

Test Plan:
- Reset, then start pulse with enable=1: step_code 0,1,2,3,4. done at step 4 -> step_code 0, busy 0, instr_count 1.
- Stall: enable low for 2 cycles at step 3 -> step_code holds 3 for both cycles, then advances to 4.
- Back-to-back: done and start together at step 5 -> step_code 1 next cycle, busy stays 1, instr_count increments by 1.
- Overrun: enable held, no done, through step 10, one more enable -> step_code 0, step_err 1, instr_count unchanged. Next start runs normally and step_err stays 1 until reset.
- Halt with done at step 6 -> halted 1, step_code 0, instr_count unchanged. start ignored while halted. resume -> IDLE. start -> step_code 1.
- Reset asserted at step 7 -> all outputs zero next cycle. With CNT_W=2, 4 completed instructions -> instr_count wraps to 0.

Source files
------------

// File: rtl/step_sequencer_pkg.sv
//------------------------------------------------------------------------------
// step_sequencer_pkg
//   Shared control definitions for the step sequencer and its step decoder.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package step_sequencer_pkg;

   localparam int DEF_STEP_W   = 5;
   localparam int DEF_MAX_STEP = 10;
   localparam int DEF_CNT_W    = 16;

   // Step code 0 leaves every decoder output low.
   localparam int STEP_IDLE    = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } seq_state_t;

endpackage : step_sequencer_pkg

`default_nettype wire

// File: rtl/step_sequencer.sv
//------------------------------------------------------------------------------
// step_sequencer
//   Control-step generator: walks each instruction through steps 1..MAX_STEP.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module step_sequencer
   import step_sequencer_pkg::*;
#(
   parameter int STEP_W   = DEF_STEP_W,
   parameter int MAX_STEP = DEF_MAX_STEP,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              enable,
   input  logic              done,
   input  logic              halt,
   input  logic              resume,
   output logic [STEP_W-1:0] step_code,
   output logic              busy,
   output logic              halted,
   output logic              last_step,
   output logic              step_err,
   output logic [CNT_W-1:0]  instr_count
);

   localparam logic [STEP_W-1:0] C_STEP_IDLE  = STEP_W'(STEP_IDLE);
   localparam logic [STEP_W-1:0] C_STEP_FIRST = STEP_W'(1);
   localparam logic [STEP_W-1:0] C_STEP_MAX   = STEP_W'(MAX_STEP);
   localparam logic [CNT_W-1:0]  C_CNT_ONE    = CNT_W'(1);

   seq_state_t        state_q, state_d;
   logic [STEP_W-1:0] step_q,  step_d;
   logic              err_q,   err_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         step_q  <= C_STEP_IDLE;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            step_d = C_STEP_IDLE;
            if (halt) begin
               state_d = ST_HALTED;
            end else if (start) begin
               state_d = ST_RUN;
               step_d  = C_STEP_FIRST;
            end
         end

         ST_RUN: begin
            if (halt) begin
               state_d = ST_HALTED;
               step_d  = C_STEP_IDLE;
            end else if (done) begin
               cnt_d = cnt_q + C_CNT_ONE;
               if (start) begin
                  step_d = C_STEP_FIRST;
               end else begin
                  state_d = ST_IDLE;
                  step_d  = C_STEP_IDLE;
               end
            end else if (!enable) begin
               step_d = step_q;
            end else if (step_q >= C_STEP_MAX) begin
               // Ran past the last step without done: abort, do not retire.
               err_d   = 1'b1;
               state_d = ST_IDLE;
               step_d  = C_STEP_IDLE;
            end else begin
               step_d = step_q + C_STEP_FIRST;
            end
         end

         ST_HALTED: begin
            step_d = C_STEP_IDLE;
            if (resume) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            step_d  = C_STEP_IDLE;
         end
      endcase
   end

   assign step_code   = step_q;
   assign busy        = (state_q == ST_RUN);
   assign halted      = (state_q == ST_HALTED);
   assign last_step   = (state_q == ST_RUN) && (step_q == C_STEP_MAX);
   assign step_err    = err_q;
   assign instr_count = cnt_q;

endmodule : step_sequencer

`default_nettype wire

// File: tb/tb_step_sequencer.sv
//------------------------------------------------------------------------------
// tb_step_sequencer
//   Directed scoreboard bench for step_sequencer (MAX_STEP=10, CNT_W=2).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_step_sequencer;

   localparam int STEP_W   = 5;
   localparam int MAX_STEP = 10;
   localparam int CNT_W    = 2;

   typedef struct packed {
      logic [STEP_W-1:0] code;
      logic              busy;
      logic              halted;
      logic              last;
      logic              err;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset, start, enable, done, halt, resume;
   logic [STEP_W-1:0] step_code;
   logic              busy, halted, last_step, step_err;
   logic [CNT_W-1:0]  instr_count;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   step_sequencer #(
      .STEP_W  (STEP_W),
      .MAX_STEP(MAX_STEP),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .enable     (enable),
      .done       (done),
      .halt       (halt),
      .resume     (resume),
      .step_code  (step_code),
      .busy       (busy),
      .halted     (halted),
      .last_step  (last_step),
      .step_err   (step_err),
      .instr_count(instr_count)
   );

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Drive one cycle of inputs, queue the expected post-edge outputs, compare.
   task automatic step(input string tag,
                       input logic rs, st, en, dn, hl, rm,
                       input int e_code, input logic e_busy, e_halted,
                       input logic e_last, e_err, input int e_cnt);
      exp_t e, got;
      reset = rs; start = st; enable = en; done = dn; halt = hl; resume = rm;
      e.code   = STEP_W'(e_code);
      e.busy   = e_busy;
      e.halted = e_halted;
      e.last   = e_last;
      e.err    = e_err;
      e.cnt    = CNT_W'(e_cnt);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk({tag, ".step_code"},   int'(step_code),   int'(got.code));
      chk({tag, ".busy"},        int'(busy),        int'(got.busy));
      chk({tag, ".halted"},      int'(halted),      int'(got.halted));
      chk({tag, ".last_step"},   int'(last_step),   int'(got.last));
      chk({tag, ".step_err"},    int'(step_err),    int'(got.err));
      chk({tag, ".instr_count"}, int'(instr_count), int'(got.cnt));
   endtask

   initial begin
      //          tag           rs st en dn hl rm  code busy hlt last err cnt
      step("reset0",          1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      step("reset1",          1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
      step("idle_ignore",     0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0);

      // Basic run with a two-cycle stall at step 3, done at step 4
      step("start",           0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0);
      step("adv2",            0, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0, 0);
      step("adv3",            0, 0, 1, 0, 0, 0,  3, 1, 0, 0, 0, 0);
      step("stall_a",         0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0);
      step("stall_b",         0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0);
      step("adv4",            0, 0, 1, 0, 0, 0,  4, 1, 0, 0, 0, 0);
      step("done4",           0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1);

      // Back-to-back at step 5, then done with enable low
      step("b2b_start",       0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1);
      for (int i = 2; i <= 5; i++)
         step("b2b_adv",      0, 0, 1, 0, 0, 0,  i, 1, 0, 0, 0, 1);
      step("b2b_done_start",  0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0, 2);
      step("done_no_en",      0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3);

      // Overrun past MAX_STEP
      step("ovr_start",       0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 3);
      for (int i = 2; i <= MAX_STEP; i++)
         step("ovr_adv",      0, 0, 1, 0, 0, 0,  i, 1, 0, (i == MAX_STEP), 0, 3);
      step("ovr_last_stall",  0, 0, 0, 0, 0, 0, 10, 1, 0, 1, 0, 3);
      step("overrun",         0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 3);
      step("post_ovr_start",  0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 1, 3);
      step("post_ovr_adv",    0, 0, 1, 0, 0, 0,  2, 1, 0, 0, 1, 3);
      step("post_ovr_wrap",   0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0);

      // Halt together with done at step 6
      step("h_start",         0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 1, 0);
      for (int i = 2; i <= 6; i++)
         step("h_adv",        0, 0, 1, 0, 0, 0,  i, 1, 0, 0, 1, 0);
      step("halt_done",       0, 0, 1, 1, 1, 0,  0, 0, 1, 0, 1, 0);
      step("halt_ign_start",  0, 1, 1, 1, 1, 0,  0, 0, 1, 0, 1, 0);
      step("resume_start",    0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0);
      step("start_after",     0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 1, 0);

      // Reset at step 7 aborts without counting and clears step_err
      for (int i = 2; i <= 7; i++)
         step("r_adv",        0, 0, 1, 0, 0, 0,  i, 1, 0, 0, 1, 0);
      step("reset_mid",       1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);

      // Halt from IDLE, then leave with resume
      step("idle_halt",       0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0);
      step("halted_hold",     0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
      step("resume",          0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0);

      // Four retirements wrap the 2-bit counter to 0
      step("w_start",         0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++)
         step("w_b2b",        0, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0, i);
      step("w_wrap",          0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_step_sequencer

`default_nettype wire
